// File: rtl/ps2_digit_key_sender_if.sv
// Request/status and PS/2 line bundle for the digit keystroke sender.
// The master side issues start/digit; the slave side reports status and drives the PS/2 lines.
interface ps2_digit_key_sender_if;
    logic       start;
    logic [3:0] digit;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2_clk;
    logic       ps2_dat;

    modport master (output start, digit, input busy, done, err, ps2_clk, ps2_dat);
    modport slave  (input start, digit, output busy, done, err, ps2_clk, ps2_dat);
endinterface

// File: rtl/ps2_digit_key_sender.sv
// Device-side PS/2 keyboard emulator: sends make, F0, make for one decimal digit.
// state | meaning
// IDLE  | waiting for start; rejects digits above 9 with an err pulse
// SEND  | shifting one 11-bit frame, 2*CLK_DIV cycles per bit
// GAP   | inter-byte pause of 4*CLK_DIV cycles, lines held high
// DONE  | single-cycle completion pulse
module ps2_digit_key_sender #(
    parameter int CLK_DIV = 2500,
    parameter bit NUMPAD  = 1'b0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    ps2_digit_key_sender_if.slave bus
);
    localparam int CW = $clog2(4 * CLK_DIV);
    localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(4 * CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]      r_bit, w_bit_nxt;
    logic [1:0]      r_byte, w_byte_nxt;
    logic [7:0]      r_code, w_code_nxt;
    logic            r_err, w_err_nxt;
    logic            r_ps2_clk, w_clk_nxt;
    logic            r_ps2_dat, w_dat_nxt;
    logic [7:0]      w_make;
    logic [7:0]      w_byte_val;
    logic [10:0]     w_frame;

    always_comb begin
        w_make = 8'h00;
        if (NUMPAD) begin
            case (bus.digit)
                4'd0: w_make = 8'h70;
                4'd1: w_make = 8'h69;
                4'd2: w_make = 8'h72;
                4'd3: w_make = 8'h7A;
                4'd4: w_make = 8'h6B;
                4'd5: w_make = 8'h73;
                4'd6: w_make = 8'h74;
                4'd7: w_make = 8'h6C;
                4'd8: w_make = 8'h75;
                4'd9: w_make = 8'h7D;
                default: w_make = 8'h00;
            endcase
        end else begin
            case (bus.digit)
                4'd0: w_make = 8'h45;
                4'd1: w_make = 8'h16;
                4'd2: w_make = 8'h1E;
                4'd3: w_make = 8'h26;
                4'd4: w_make = 8'h25;
                4'd5: w_make = 8'h2E;
                4'd6: w_make = 8'h36;
                4'd7: w_make = 8'h3D;
                4'd8: w_make = 8'h3E;
                4'd9: w_make = 8'h46;
                default: w_make = 8'h00;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_code_nxt  = r_code;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.digit <= 4'd9) begin
                        w_state_nxt = S_SEND;
                        w_code_nxt  = w_make;
                        w_byte_nxt  = 2'd0;
                        w_bit_nxt   = 4'd0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 4'd10) begin
                        w_bit_nxt   = 4'd0;
                        w_state_nxt = (r_byte == 2'd2) ? S_DONE : S_GAP;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_byte_nxt  = r_byte + 2'd1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = 2'd0;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line levels are computed for the coming cycle so both pins come straight off flops.
        w_byte_val = (w_byte_nxt == 2'd1) ? 8'hF0 : w_code_nxt;
        w_frame    = {1'b1, ~(^w_byte_val), w_byte_val, 1'b0};
        w_clk_nxt  = 1'b1;
        w_dat_nxt  = 1'b1;
        if (w_state_nxt == S_SEND) begin
            w_clk_nxt = (w_cnt_nxt < HALF);
            w_dat_nxt = w_frame[w_bit_nxt];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= 4'd0;
            r_byte    <= 2'd0;
            r_code    <= 8'h00;
            r_err     <= 1'b0;
            r_ps2_clk <= 1'b1;
            r_ps2_dat <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_byte    <= w_byte_nxt;
            r_code    <= w_code_nxt;
            r_err     <= w_err_nxt;
            r_ps2_clk <= w_clk_nxt;
            r_ps2_dat <= w_dat_nxt;
        end
    end

    assign bus.busy    = (r_state == S_SEND) || (r_state == S_GAP);
    assign bus.done    = (r_state == S_DONE);
    assign bus.err     = r_err;
    assign bus.ps2_clk = r_ps2_clk;
    assign bus.ps2_dat = r_ps2_dat;
endmodule

// File: doc/ps2_digit_key_sender.md
# ps2_digit_key_sender

- Device-side PS/2 keyboard emulator.
- On a start request it takes a decimal digit (0–9) and transmits that key's complete keystroke as PS/2 set-2 frames: make code, break prefix `F0`, make code.
- Sits opposite the scan-code-to-number decoder. It drives its input in loopback tests on the board and generates keyboard traffic in simulation, with no physical keyboard needed.

## Interface
- `CLK_DIV`, default 2500: system-clock cycles per PS/2 clock half-period (10 kHz PS/2 clock at 50 MHz); legal values ≥ 2.
- `NUMPAD`, default 0: 0 selects top-row digit codes, 1 selects numeric-keypad codes.

Ports:
- `CLOCK_50`, input, 1: system clock, rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to send one keystroke; sampled on the rising edge.
- `digit`, input, 4: digit to send; sampled in the cycle `start` is accepted.
- `busy`, output, 1: high while a keystroke is in flight.
- `done`, output, 1: one-cycle pulse when a keystroke completes.
- `err`, output, 1: one-cycle pulse when a request is rejected.
- `ps2_clk`, output, 1: PS/2 clock, idle high.
- `ps2_dat`, output, 1: PS/2 data, idle high.

## Operation
- Reset values: `busy`=0, `done`=0, `err`=0, `ps2_clk`=1, `ps2_dat`=1, FSM in IDLE, all counters 0.
- Code map, top row (`NUMPAD`=0):
  - 0→45, 1→16, 2→1E, 3→26, 4→25
  - 5→2E, 6→36, 7→3D, 8→3E, 9→46
- Code map, keypad (`NUMPAD`=1):
  - 0→70, 1→69, 2→72, 3→7A, 4→6B
  - 5→73, 6→74, 7→6C, 8→75, 9→7D
- Request handling in IDLE with `start`=1:
  - `digit` ≤ 9: latch the make code, go to SEND, byte index 0.
  - `digit` > 9: stay in IDLE and pulse `err` for one cycle.
- `start` while not in IDLE is ignored: no `err`, and the latched code is unchanged.
- Byte sequence: byte 0 = make, byte 1 = `F0`, byte 2 = make.
- Frame format: 11 bits.
  - Start bit 0.
  - 8 data bits, LSB first.
  - Odd parity bit, i.e. the count of ones in data plus parity is odd.
  - Stop bit 1.
- States:
  - IDLE: waits for a request.
  - SEND: bit counter 0–10, phase counter 0 to 2·`CLK_DIV`−1.
  - GAP: counter 0 to 4·`CLK_DIV`−1.
  - DONE: lasts exactly one cycle.
- Transitions:
  - SEND → GAP after bit 10 of byte 0 or byte 1.
  - GAP → SEND with the byte index incremented.
  - SEND → DONE after bit 10 of byte 2.
  - DONE → IDLE.
- Outputs by state:
  - `busy` = 1 in SEND and GAP.
  - `done` = 1 in DONE only.
  - In GAP, `ps2_clk` and `ps2_dat` are both held at 1.

## Timing
- `start` is accepted at edge E0. From edge E0+1, `busy`=1 and `ps2_dat` carries the start bit.
- Each bit period is 2·`CLK_DIV` cycles:
  - `ps2_dat` changes only at cycle 0 of the period.
  - `ps2_clk`=1 for cycles 0 to `CLK_DIV`−1.
  - `ps2_clk`=0 for cycles `CLK_DIV` to 2·`CLK_DIV`−1.
- The receiver samples on the falling edge of `ps2_clk`. Data is therefore stable for `CLK_DIV` cycles before that edge and through the low half.
- `busy` stays high for exactly 3·22·`CLK_DIV` + 2·4·`CLK_DIV` = 74·`CLK_DIV` cycles.
- `done` rises in the same cycle `busy` falls. A new `start` is accepted in the cycle after `done`.
- `ps2_clk` and `ps2_dat` are registered outputs with no combinational path from inputs.
- Reset mid-frame: all outputs return to their reset values asynchronously. No partial frame resumes after release.
- The `err` pulse occurs at E0+1; `busy` stays 0.

## Test plan
All scenarios use `CLK_DIV`=4 unless noted.
- Reset mid-stream: `NUMPAD`=0, `digit`=1, `start` pulse. Assert `resetn`=0 during byte 1, bit 4.
  - `ps2_clk`, `ps2_dat` = 1 and `busy` = 0 immediately.
  - Release reset and idle 400 cycles: no edges on `ps2_clk`, no `done`.
- Top-row digit 1: `NUMPAD`=0, `digit`=1, one-cycle `start`.
  - Sampled bytes are 16, F0, 16.
  - Parity bits are 0, 1, 0.
  - `busy` high for 296 cycles, then one `done` pulse.
- Keypad digit 1: `NUMPAD`=1, `digit`=1.
  - Frames are 69, F0, 69.
  - Byte 0 bit sequence: 0,1,0,0,1,0,1,1,0,1,1.
- Busy and invalid requests:
  - Pulse `start` every 10 cycles while busy: no `err`, the transmitted code is unchanged, exactly one `done`.
  - Then `digit`=12 with `start`: one `err` pulse at E0+1, `busy` stays 0, no `ps2_clk` edges.
- Exhaustive digit sweep: back-to-back `digit`=0..9 in both `NUMPAD` settings, each `start` issued the cycle after `done`.
  - Receiver model decodes every mapped make code, e.g. 0 → 45 top-row, 70 keypad.
  - Parity is odd on every frame.
  - Gaps between bytes are 16 cycles.
- Timing check, `CLK_DIV`=2500:
  - `ps2_clk` half-periods are exactly 2500 cycles.
  - `ps2_dat` never changes while `ps2_clk`=0.
